// File: rtl/spw_fct_credit_ctrl.sv
// SpaceWire flow-control credit scheduler: decides when to emit FCTs for the RX FIFO
// and tracks credit granted by the far end for local N-char transmission.
module spw_fct_credit_ctrl #(
  parameter int AWIDTH     = 6,
  parameter int MAX_CREDIT = 56,
  parameter int FCT_CHUNK  = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              link_run,
  input  logic [AWIDTH-1:0] rx_fifo_count,
  input  logic              rx_nchar,
  output logic              fct_req,
  input  logic              fct_ack,
  input  logic              fct_rcvd,
  input  logic              tx_nchar,
  output logic [5:0]        rx_credit,
  output logic [5:0]        tx_credit,
  output logic              tx_ready,
  output logic              rx_credit_error,
  output logic              tx_credit_error
);

  localparam int CW = 7;
  localparam logic [CW-1:0] DEPTH = CW'((1 << AWIDTH) - 1);
  localparam logic [CW-1:0] MAXC  = CW'(MAX_CREDIT);
  localparam logic [CW-1:0] CHUNK = CW'(FCT_CHUNK);

  typedef enum logic [1:0] {DISABLED, IDLE, REQ, GAP} state_t;

  state_t          state, state_next;
  logic [CW-1:0]   free, rx_plus, tx_plus;
  logic            grant_ok, ack_taken, tx_ovf;
  logic [5:0]      rx_credit_next, tx_credit_next;
  logic            rx_err_next, tx_err_next;

  function automatic logic [5:0] sat_credit(input logic [CW-1:0] v);
    return (v > MAXC) ? MAXC[5:0] : v[5:0];
  endfunction

  assign free      = DEPTH - CW'(rx_fifo_count);
  assign rx_plus   = {1'b0, rx_credit} + CHUNK;
  assign tx_plus   = {1'b0, tx_credit} + CHUNK;
  assign grant_ok  = (rx_plus <= free) && (rx_plus <= MAXC);
  assign ack_taken = fct_ack && (state == REQ);
  assign tx_ovf    = fct_rcvd && (tx_plus > MAXC);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= DISABLED;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    fct_req    = 1'b0;
    if (!link_run) begin
      state_next = DISABLED;
    end else begin
      case (state)
        DISABLED: state_next = IDLE;
        IDLE:     if (grant_ok) state_next = REQ;
        REQ: begin
          fct_req = 1'b1;
          if (fct_ack) state_next = GAP;
        end
        GAP:      state_next = IDLE;
        default:  state_next = DISABLED;
      endcase
    end
  end

  // An ack coinciding with an incoming N-char nets +7 and cannot underflow.
  always_comb begin
    rx_credit_next = rx_credit;
    rx_err_next    = rx_credit_error;
    if (!link_run) begin
      rx_credit_next = '0;
      rx_err_next    = 1'b0;
    end else if (ack_taken) begin
      rx_credit_next = sat_credit(rx_plus - CW'(rx_nchar));
    end else if (rx_nchar) begin
      if (rx_credit != '0) rx_credit_next = rx_credit - 6'd1;
      else                 rx_err_next    = 1'b1;
    end
  end

  // Overflow check is on the pre-update credit; a rejected FCT still lets tx_nchar consume.
  always_comb begin
    tx_credit_next = tx_credit;
    tx_err_next    = tx_credit_error;
    if (!link_run) begin
      tx_credit_next = '0;
      tx_err_next    = 1'b0;
    end else begin
      if (fct_rcvd && !tx_ovf)
        tx_credit_next = sat_credit(tx_plus - CW'(tx_nchar));
      else if (tx_nchar && tx_credit != '0)
        tx_credit_next = tx_credit - 6'd1;
      if (tx_ovf) tx_err_next = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rx_credit       <= '0;
      tx_credit       <= '0;
      tx_ready        <= 1'b0;
      rx_credit_error <= 1'b0;
      tx_credit_error <= 1'b0;
    end else begin
      rx_credit       <= rx_credit_next;
      tx_credit       <= tx_credit_next;
      tx_ready        <= (tx_credit_next != '0);
      rx_credit_error <= rx_err_next;
      tx_credit_error <= tx_err_next;
    end
  end

endmodule
